// File: rtl/button_debouncer.sv
// Debounces a raw button through a 2-flop synchronizer and a counting FSM; emits level, press/release pulses and counter enable.
// Latency N+2 clk edges from first high/low sample to accepted change; no backpressure, outputs registered.
module button_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 500_000,
    parameter int unsigned TOGGLE_MODE     = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic enable_out
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE_LOW  = 2'd0,
        WAIT_HIGH = 2'd1,
        IDLE_HIGH = 2'd2,
        WAIT_LOW  = 2'd3
    } state_t;

    logic          s1_q;
    logic          s2_q;
    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_inc_d;
    logic          btn_level_q;
    logic          press_q;
    logic          release_q;
    logic          enable_q;

    // btn_in is asynchronous; only s2_q is safe to use downstream.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= btn_in;
            s2_q <= s1_q;
        end
    end

    assign cnt_inc_d = cnt_q + CNT_ONE;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE_LOW;
            cnt_q       <= '0;
            btn_level_q <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            enable_q    <= 1'b0;
        end else begin
            press_q   <= 1'b0;
            release_q <= 1'b0;
            case (state_q)
                IDLE_LOW: begin
                    if (s2_q) begin
                        state_q <= WAIT_HIGH;
                        cnt_q   <= CNT_ONE;
                    end else begin
                        cnt_q <= '0;
                    end
                end
                WAIT_HIGH: begin
                    if (!s2_q) begin
                        state_q <= IDLE_LOW;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q     <= IDLE_HIGH;
                        cnt_q       <= '0;
                        btn_level_q <= 1'b1;
                        press_q     <= 1'b1;
                        // Toggle mode flips on press only; level mode tracks btn_level.
                        if (TOGGLE_MODE != 0) begin
                            enable_q <= ~enable_q;
                        end else begin
                            enable_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_inc_d;
                    end
                end
                IDLE_HIGH: begin
                    if (!s2_q) begin
                        state_q <= WAIT_LOW;
                        cnt_q   <= CNT_ONE;
                    end else begin
                        cnt_q <= '0;
                    end
                end
                WAIT_LOW: begin
                    if (s2_q) begin
                        state_q <= IDLE_HIGH;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q     <= IDLE_LOW;
                        cnt_q       <= '0;
                        btn_level_q <= 1'b0;
                        release_q   <= 1'b1;
                        if (TOGGLE_MODE == 0) begin
                            enable_q <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_inc_d;
                    end
                end
                default: begin
                    state_q <= IDLE_LOW;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign btn_level     = btn_level_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign enable_out    = enable_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer with N=4: a toggle-mode and a level-mode instance share clk/reset/btn_in.
// A window-based reference model of the acceptance rule is compared against both instances every cycle.
module tb_button_debouncer;

    localparam int N = 4;

    logic clk    = 1'b0;
    logic reset  = 1'b1;
    logic btn_in = 1'b0;

    logic lvl_t, prs_t, rel_t, en_t;
    logic lvl_l, prs_l, rel_l, en_l;

    int n_vec = 0;
    int n_err = 0;
    int n_prs = 0;
    int n_rel = 0;

    button_debouncer #(.DEBOUNCE_CYCLES(N), .TOGGLE_MODE(1)) dut_t (
        .clk(clk), .reset(reset), .btn_in(btn_in),
        .btn_level(lvl_t), .press_pulse(prs_t), .release_pulse(rel_t), .enable_out(en_t)
    );

    button_debouncer #(.DEBOUNCE_CYCLES(N), .TOGGLE_MODE(0)) dut_l (
        .clk(clk), .reset(reset), .btn_in(btn_in),
        .btn_level(lvl_l), .press_pulse(prs_l), .release_pulse(rel_l), .enable_out(en_l)
    );

    always #5 clk = ~clk;

    // Reference: a level flips when the last N synchronized samples (raw input
    // delayed two edges, zero before reset history) all differ from it.
    logic bq[$];
    logic s2q[$];
    logic m_level = 1'b0, m_press = 1'b0, m_release = 1'b0, m_en_t = 1'b0;
    logic s2_now;
    bit   all_diff;
    int   m_nprs = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            bq.delete();
            s2q.delete();
            m_level = 1'b0; m_press = 1'b0; m_release = 1'b0; m_en_t = 1'b0;
        end else begin
            s2_now = (bq.size() >= 2) ? bq[bq.size()-2] : 1'b0;
            bq.push_back(btn_in);
            if (bq.size() > 2) void'(bq.pop_front());
            s2q.push_back(s2_now);
            if (s2q.size() > N) void'(s2q.pop_front());
            m_press = 1'b0;
            m_release = 1'b0;
            all_diff = (s2q.size() == N);
            foreach (s2q[i]) if (s2q[i] == m_level) all_diff = 1'b0;
            if (all_diff) begin
                m_level = ~m_level;
                if (m_level) begin
                    m_press = 1'b1;
                    m_en_t = ~m_en_t;
                    m_nprs++;
                end else begin
                    m_release = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        n_vec++;
        if ({lvl_t, prs_t, rel_t, en_t} !== {m_level, m_press, m_release, m_en_t}) begin
            n_err++;
            $display("FAIL scoreboard_toggle t=%0t got lvl/prs/rel/en=%b%b%b%b want %b%b%b%b",
                     $time, lvl_t, prs_t, rel_t, en_t, m_level, m_press, m_release, m_en_t);
        end
        n_vec++;
        if ({lvl_l, prs_l, rel_l, en_l} !== {m_level, m_press, m_release, m_level}) begin
            n_err++;
            $display("FAIL scoreboard_level t=%0t got lvl/prs/rel/en=%b%b%b%b want %b%b%b%b",
                     $time, lvl_l, prs_l, rel_l, en_l, m_level, m_press, m_release, m_level);
        end
        n_vec++;
        if (prs_t === 1'b1 && rel_t === 1'b1) begin
            n_err++;
            $display("FAIL pulse_overlap t=%0t got press=1 release=1 want not both", $time);
        end
        if (prs_t === 1'b1) n_prs++;
        if (rel_t === 1'b1) n_rel++;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        btn_in = 1'b0;
        tick(2);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        btn_in = 1'b0;
        tick(2);
        n_vec++;
        if ({lvl_t, prs_t, rel_t, en_t, lvl_l, prs_l, rel_l, en_l} !== 8'h00) begin
            n_err++;
            $display("FAIL reset_values got %b%b%b%b_%b%b%b%b want 0000_0000",
                     lvl_t, prs_t, rel_t, en_t, lvl_l, prs_l, rel_l, en_l);
        end
        reset = 1'b0;
    endtask

    task automatic test_clean_press();
        do_reset();
        btn_in = 1'b1;
        tick(5);
        n_vec++;
        if (lvl_t !== 1'b0 || prs_t !== 1'b0) begin
            n_err++;
            $display("FAIL press_early got lvl=%b prs=%b want 0 0 after edge 5", lvl_t, prs_t);
        end
        tick(1);
        n_vec++;
        if ({lvl_t, prs_t, en_t} !== 3'b111) begin
            n_err++;
            $display("FAIL press_edge6 got lvl/prs/en=%b%b%b want 111", lvl_t, prs_t, en_t);
        end
        tick(1);
        n_vec++;
        if ({lvl_t, prs_t} !== 2'b10) begin
            n_err++;
            $display("FAIL press_one_cycle got lvl/prs=%b%b want 10", lvl_t, prs_t);
        end
        tick(3);
        btn_in = 1'b0;
        tick(5);
        n_vec++;
        if (lvl_t !== 1'b1 || rel_t !== 1'b0) begin
            n_err++;
            $display("FAIL release_early got lvl=%b rel=%b want 1 0", lvl_t, rel_t);
        end
        tick(1);
        n_vec++;
        if ({lvl_t, rel_t, en_t} !== 3'b011) begin
            n_err++;
            $display("FAIL release_edge6 got lvl/rel/en=%b%b%b want 011", lvl_t, rel_t, en_t);
        end
    endtask

    task automatic test_bounce();
        logic [19:0] pat;
        int p0;
        do_reset();
        pat = 20'b1100_1100_1110_0000_0000;
        p0 = n_prs;
        for (int i = 0; i < 26; i++) begin
            btn_in = (i < 20) ? pat[19-i] : 1'b0;
            tick(1);
            n_vec++;
            if ({lvl_t, en_t, prs_t, rel_t} !== 4'b0000) begin
                n_err++;
                $display("FAIL bounce_cycle%0d got lvl/en/prs/rel=%b%b%b%b want 0000",
                         i, lvl_t, en_t, prs_t, rel_t);
            end
        end
        n_vec++;
        if (n_prs != p0) begin
            n_err++;
            $display("FAIL bounce_press_count got %0d want 0", n_prs - p0);
        end
    endtask

    task automatic test_toggle();
        int p0, r0;
        do_reset();
        p0 = n_prs;
        r0 = n_rel;
        for (int k = 0; k < 3; k++) begin
            btn_in = 1'b1;
            tick(8);
            n_vec++;
            if (en_t !== ((k % 2) == 0)) begin
                n_err++;
                $display("FAIL toggle_en_press%0d got %b want %b", k, en_t, (k % 2) == 0);
            end
            btn_in = 1'b0;
            tick(10);
        end
        n_vec++;
        if (n_prs - p0 != 3 || n_rel - r0 != 3) begin
            n_err++;
            $display("FAIL toggle_pulse_counts got press=%0d release=%0d want 3 3",
                     n_prs - p0, n_rel - r0);
        end
    endtask

    task automatic test_level_mode();
        do_reset();
        btn_in = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick(1);
            n_vec++;
            if (en_l !== (i >= 6) || en_l !== lvl_l) begin
                n_err++;
                $display("FAIL level_rise_edge%0d got en=%b lvl=%b want en=%b", i, en_l, lvl_l, i >= 6);
            end
        end
        btn_in = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick(1);
            n_vec++;
            if (en_l !== (i < 6) || en_l !== lvl_l) begin
                n_err++;
                $display("FAIL level_fall_edge%0d got en=%b lvl=%b want en=%b", i, en_l, lvl_l, i < 6);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        btn_in = 1'b1;
        tick(4);
        reset = 1'b1;
        #1;
        n_vec++;
        if ({lvl_t, prs_t, rel_t, en_t} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_mid_wait got %b%b%b%b want 0000", lvl_t, prs_t, rel_t, en_t);
        end
        tick(1);
        reset = 1'b0;
        tick(5);
        n_vec++;
        if (lvl_t !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid_early got lvl=%b want 0", lvl_t);
        end
        tick(1);
        n_vec++;
        if ({lvl_t, prs_t, en_t} !== 3'b111) begin
            n_err++;
            $display("FAIL reset_held_press got lvl/prs/en=%b%b%b want 111", lvl_t, prs_t, en_t);
        end
        reset = 1'b1;
        #1;
        n_vec++;
        if ({lvl_t, prs_t, en_t, lvl_l, prs_l, en_l} !== 6'b000000) begin
            n_err++;
            $display("FAIL reset_cut_pulse got %b%b%b_%b%b%b want 000_000",
                     lvl_t, prs_t, en_t, lvl_l, prs_l, en_l);
        end
        tick(1);
        btn_in = 1'b0;
        reset = 1'b0;
    endtask

    task automatic test_boundary();
        int p0, r0;
        do_reset();
        p0 = n_prs;
        btn_in = 1'b1;
        tick(N - 1);
        btn_in = 1'b0;
        tick(10);
        n_vec++;
        if (n_prs != p0 || lvl_t !== 1'b0) begin
            n_err++;
            $display("FAIL boundary_n_minus_1 got presses=%0d lvl=%b want 0 0", n_prs - p0, lvl_t);
        end
        p0 = n_prs;
        r0 = n_rel;
        btn_in = 1'b1;
        tick(N);
        btn_in = 1'b0;
        tick(10);
        n_vec++;
        if (n_prs - p0 != 1 || n_rel - r0 != 1 || lvl_t !== 1'b0) begin
            n_err++;
            $display("FAIL boundary_n got presses=%0d releases=%0d lvl=%b want 1 1 0",
                     n_prs - p0, n_rel - r0, lvl_t);
        end
    endtask

    task automatic test_random();
        int p0, m0;
        do_reset();
        p0 = n_prs;
        m0 = m_nprs;
        for (int s = 0; s < 120; s++) begin
            btn_in = ~btn_in;
            if ($urandom_range(0, 29) == 0) begin
                reset = 1'b1;
                tick(1);
                reset = 1'b0;
            end
            tick($urandom_range(1, 2 * N));
        end
        btn_in = 1'b0;
        tick(2 * N + 4);
        n_vec++;
        if (n_prs - p0 != m_nprs - m0) begin
            n_err++;
            $display("FAIL random_press_total got %0d want %0d", n_prs - p0, m_nprs - m0);
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_toggle();
        test_level_mode();
        test_reset_mid();
        test_boundary();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
